// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS data-memory port sequencer: state encoding,
// port-owner constants and default bus widths.
package mips_mem_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the IF port, D port and memory-side signals around the shared memory
// sequencer; slave is the sequencer's view, master the surrounding system's.
interface mem_port_arbiter_if import mips_mem_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              if_stall;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;
  logic              d_stall;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rdata, if_valid, if_stall,
    output d_gnt, d_rdata, d_valid, d_stall,
    output mem_addr, mem_wdata, mem_we, mem_re
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rdata, if_valid, if_stall,
    input  d_gnt, d_rdata, d_valid, d_stall,
    input  mem_addr, mem_wdata, mem_we, mem_re
  );

endinterface

// File: rtl/arb_rr2.sv
// Two-requester round-robin picker: a lone requester wins outright, a tie goes
// to the port that did not win the previous access.
module arb_rr2 import mips_mem_pkg::*; (
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       winner
);

  // Pick the winner from the current request pair
  always_comb begin
    winner = OWN_IF;
    case (req)
      2'b01:   winner = OWN_IF;
      2'b10:   winner = OWN_D;
      2'b11:   winner = ~last_owner;
      default: winner = OWN_IF;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported data memory between the IF and D ports: arbitrates,
// runs each access for LAT cycles, then pulses valid with the read data.
module mem_port_arbiter import mips_mem_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LAT    = 2
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

  state_t            state_r;
  logic              owner_r;
  logic              last_owner_r;
  logic [3:0]        cnt_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic              mem_we_r;
  logic              mem_re_r;
  logic              if_gnt_r;
  logic              d_gnt_r;
  logic              if_valid_r;
  logic              d_valid_r;
  logic [DATA_W-1:0] if_rdata_r;
  logic [DATA_W-1:0] d_rdata_r;
  logic              winner_s;

  arb_rr2 u_arb (
    .req        ({bus.d_req, bus.if_req}),
    .last_owner (last_owner_r),
    .winner     (winner_s)
  );

  // Sequencer: the memory-side registers double as the latched request fields
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      owner_r      <= OWN_IF;
      last_owner_r <= OWN_IF;
      cnt_r        <= 4'd0;
      mem_addr_r   <= '0;
      mem_wdata_r  <= '0;
      mem_we_r     <= 1'b0;
      mem_re_r     <= 1'b0;
      if_gnt_r     <= 1'b0;
      d_gnt_r      <= 1'b0;
      if_valid_r   <= 1'b0;
      d_valid_r    <= 1'b0;
      if_rdata_r   <= '0;
      d_rdata_r    <= '0;
    end else begin
      if_gnt_r   <= 1'b0;
      d_gnt_r    <= 1'b0;
      if_valid_r <= 1'b0;
      d_valid_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.if_req || bus.d_req) begin
            owner_r <= winner_s;
            cnt_r   <= LAT_M1;
            state_r <= ACCESS;
            if (winner_s == OWN_D) begin
              mem_addr_r  <= bus.d_addr;
              mem_wdata_r <= bus.d_wdata;
              mem_we_r    <= bus.d_we;
              mem_re_r    <= ~bus.d_we;
              d_gnt_r     <= 1'b1;
            end else begin
              mem_addr_r <= bus.if_addr;
              mem_we_r   <= 1'b0;
              mem_re_r   <= 1'b1;
              if_gnt_r   <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (cnt_r == 4'd0) begin
            // Writes leave both rdata registers untouched
            if (!mem_we_r && owner_r == OWN_IF) begin
              if_rdata_r <= bus.mem_rdata;
            end
            if (!mem_we_r && owner_r == OWN_D) begin
              d_rdata_r <= bus.mem_rdata;
            end
            if_valid_r   <= (owner_r == OWN_IF);
            d_valid_r    <= (owner_r == OWN_D);
            last_owner_r <= owner_r;
            mem_we_r     <= 1'b0;
            mem_re_r     <= 1'b0;
            state_r      <= DONE;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        DONE:    state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  assign bus.if_gnt    = if_gnt_r;
  assign bus.d_gnt     = d_gnt_r;
  assign bus.if_valid  = if_valid_r;
  assign bus.d_valid   = d_valid_r;
  assign bus.if_rdata  = if_rdata_r;
  assign bus.d_rdata   = d_rdata_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_re    = mem_re_r;
  assign bus.if_stall  = bus.if_req & ~if_valid_r;
  assign bus.d_stall   = bus.d_req & ~d_valid_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-schedule model,
// plus directed scenarios and latency probes of LAT=1 and LAT=15 builds.
module tb_mem_port_arbiter;
  import mips_mem_pkg::*;

  localparam int LAT = 2;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } cmd_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] env_mem [64];
  logic [31:0] ref_mem [64];
  bit          load_env;

  assign bus.mem_rdata = bus.mem_re ? env_mem[bus.mem_addr[7:2]] : 32'h0;

  // Memory behind the port: preload from the reference image, then accept writes
  always @(posedge clk) begin
    if (load_env) begin
      for (int i = 0; i < 64; i++) env_mem[i] <= ref_mem[i];
    end else if (bus.mem_we) begin
      env_mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    end
  end

  // Edge counter used as the model's time base
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model: arbiter is a schedule of transactions; one starting at edge s grants
  // in cycle s, drives memory for LAT cycles, completes in cycle s+LAT and can
  // be followed by a new grant decision at edge s+LAT+2.
  int          idle_from;
  int          m_s;
  bit          m_busy;
  logic        m_owner, m_last, m_we;
  logic [31:0] m_addr, m_wdata, e_if_rdata, e_d_rdata;
  bit          m_g_d;

  cmd_t if_q[$], d_q[$];
  cmd_t d_cur;
  bit   if_out, d_out;
  bit   rand_mode, log_en;
  logic glog[$];
  int   n_if_v, n_d_v, n_we_cyc;
  logic [31:0] last_if_rd, last_d_rd;

  function automatic cmd_t rand_cmd(input bit allow_write);
    cmd_t c;
    c.addr  = {24'h0, 6'($urandom), 2'b00};
    c.we    = allow_write ? 1'($urandom) : 1'b0;
    c.wdata = $urandom;
    return c;
  endfunction

  task automatic step();
    logic g_if, g_d, v_if, v_d, act;
    int   k;
    cmd_t c;
    @(negedge clk);
    k = cyc;
    if (!rst) begin
      m_busy = 1'b0; m_last = OWN_IF; m_we = 1'b0; m_addr = 32'h0;
      e_if_rdata = 32'h0; e_d_rdata = 32'h0;
      idle_from = k + 1;
    end else if (k == idle_from) begin
      if (bus.if_req || bus.d_req) begin
        if (bus.if_req && bus.d_req) m_owner = ~m_last;
        else m_owner = bus.d_req ? OWN_D : OWN_IF;
        m_busy = 1'b1;
        m_s    = k;
        if (m_owner == OWN_D) begin
          m_addr = bus.d_addr; m_we = bus.d_we; m_wdata = bus.d_wdata;
        end else begin
          m_addr = bus.if_addr; m_we = 1'b0;
        end
        idle_from = k + LAT + 2;
      end else begin
        idle_from = k + 1;
      end
    end
    g_if = m_busy && k == m_s && m_owner == OWN_IF;
    g_d  = m_busy && k == m_s && m_owner == OWN_D;
    act  = m_busy && k >= m_s && k < m_s + LAT;
    v_if = m_busy && k == m_s + LAT && m_owner == OWN_IF;
    v_d  = m_busy && k == m_s + LAT && m_owner == OWN_D;
    if (v_if || v_d) begin
      m_last = m_owner;
      if (m_we) ref_mem[m_addr[7:2]] = m_wdata;
      else if (v_if) e_if_rdata = ref_mem[m_addr[7:2]];
      else e_d_rdata = ref_mem[m_addr[7:2]];
    end

    check_eq("if_gnt",   bus.if_gnt,   g_if);
    check_eq("d_gnt",    bus.d_gnt,    g_d);
    check_eq("mem_re",   bus.mem_re,   act && !m_we);
    check_eq("mem_we",   bus.mem_we,   act && m_we);
    check_eq("mem_addr", bus.mem_addr, m_addr);
    if (act && m_we) check_eq("mem_wdata", bus.mem_wdata, m_wdata);
    check_eq("if_valid", bus.if_valid, v_if);
    check_eq("d_valid",  bus.d_valid,  v_d);
    check_eq("if_rdata", bus.if_rdata, e_if_rdata);
    check_eq("d_rdata",  bus.d_rdata,  e_d_rdata);
    check_eq("if_stall", bus.if_stall, bus.if_req & ~v_if);
    check_eq("d_stall",  bus.d_stall,  bus.d_req & ~v_d);

    if (log_en && bus.if_gnt) glog.push_back(OWN_IF);
    if (log_en && bus.d_gnt)  glog.push_back(OWN_D);
    if (bus.if_valid) begin n_if_v++; last_if_rd = bus.if_rdata; end
    if (bus.d_valid)  begin n_d_v++;  last_d_rd  = bus.d_rdata;  end
    if (bus.mem_we) n_we_cyc++;
    if (v_if || v_d) m_busy = 1'b0;
    m_g_d = g_d;

    // Requesters: hold req until the grant, then wait for completion
    if (g_if) begin bus.if_req = 1'b0; if_out = 1'b1; end
    if (g_d)  begin bus.d_req  = 1'b0; d_out  = 1'b1; end
    if (v_if) if_out = 1'b0;
    if (v_d)  d_out  = 1'b0;
    if (rand_mode && if_q.size() == 0 && $urandom_range(0, 99) < 35) if_q.push_back(rand_cmd(1'b0));
    if (rand_mode && d_q.size() == 0 && $urandom_range(0, 99) < 35) d_q.push_back(rand_cmd(1'b1));
    if (!bus.if_req && !if_out && if_q.size() > 0) begin
      c = if_q.pop_front();
      bus.if_req = 1'b1; bus.if_addr = c.addr;
    end
    if (!bus.d_req && !d_out && d_q.size() > 0) begin
      c = d_q.pop_front();
      d_cur = c;
      bus.d_req = 1'b1; bus.d_addr = c.addr; bus.d_we = c.we; bus.d_wdata = c.wdata;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (n < 400 && (m_busy || if_q.size() > 0 || d_q.size() > 0 ||
                       bus.if_req || bus.d_req || if_out || d_out)) begin
      step();
      n++;
    end
    if (n >= 400) check_eq("idle_timeout", 64'd1, 64'd0);
    repeat (2) step();
  endtask

  // Latency probes on LAT=1 and LAT=15 builds
  for (genvar g = 0; g < 2; g++) begin : g_aux
    localparam int AL = (g == 0) ? 1 : 15;
    logic arst;
    bit   done;
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) abus ();
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(AL)) adut (
      .clk (clk),
      .rst (arst),
      .bus (abus)
    );
    assign abus.mem_rdata = abus.mem_re ? (abus.mem_addr ^ 32'h5A5A_A5A5) : 32'h0;

    initial begin
      logic [31:0] a;
      int   n;
      bit   seen;
      logic use_d;
      done = 1'b0;
      arst = 1'b0;
      abus.if_req = 1'b0; abus.if_addr = 32'h0;
      abus.d_req = 1'b0; abus.d_we = 1'b0; abus.d_addr = 32'h0; abus.d_wdata = 32'h0;
      repeat (3) @(negedge clk);
      arst = 1'b1;
      for (int t = 0; t < 4; t++) begin
        @(negedge clk);
        a = {24'h0, 6'($urandom), 2'b00};
        use_d = 1'(t);
        if (use_d) begin abus.d_req = 1'b1; abus.d_addr = a; end
        else begin abus.if_req = 1'b1; abus.if_addr = a; end
        seen = 1'b0;
        n = 0;
        while (!seen && n < 40) begin
          @(negedge clk);
          n++;
          if (n == 1) check_eq($sformatf("lat%0d_gnt", AL), use_d ? abus.d_gnt : abus.if_gnt, 64'd1);
          abus.if_req = 1'b0;
          abus.d_req  = 1'b0;
          if (abus.if_valid || abus.d_valid) begin
            seen = 1'b1;
            check_eq($sformatf("lat%0d_cycles", AL), 64'(n), 64'(AL + 1));
            check_eq($sformatf("lat%0d_rdata", AL), use_d ? abus.d_rdata : abus.if_rdata,
                     a ^ 32'h5A5A_A5A5);
          end
        end
        if (!seen) check_eq($sformatf("lat%0d_timeout", AL), 64'd0, 64'd1);
      end
      done = 1'b1;
    end
  end

  initial begin
    int n;
    cmd_t c;
    bus.if_req = 1'b0; bus.if_addr = 32'h0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
    for (int i = 0; i < 64; i++) ref_mem[i] = $urandom;
    ref_mem[16] = 32'hDEAD_BEEF;
    load_env = 1'b1;
    m_busy = 1'b0; m_last = OWN_IF;
    repeat (4) step();
    load_env = 1'b0;
    check_eq("rst_mem_re", bus.mem_re, 64'd0);
    check_eq("rst_if_rdata", bus.if_rdata, 64'd0);
    rst = 1'b1;
    step();

    // Both ports, three accesses each, requesting continuously
    for (int i = 0; i < 3; i++) begin
      if_q.push_back(rand_cmd(1'b0));
      d_q.push_back(rand_cmd(1'b0));
    end
    n_if_v = 0; n_d_v = 0;
    log_en = 1'b1;
    wait_idle();
    log_en = 1'b0;
    check_eq("order_len", 64'(glog.size()), 64'd6);
    for (int i = 0; i < 6 && i < glog.size(); i++)
      check_eq($sformatf("order_%0d", i), glog[i], (i % 2 == 0) ? OWN_D : OWN_IF);
    check_eq("if_valid_cnt", 64'(n_if_v), 64'd3);
    check_eq("d_valid_cnt",  64'(n_d_v),  64'd3);

    // IF read of the preloaded word
    c.addr = 32'h40; c.we = 1'b0; c.wdata = 32'h0;
    if_q.push_back(c);
    wait_idle();
    check_eq("if_read_40", last_if_rd, 32'hDEAD_BEEF);

    // D write then read back at 0x80
    n_we_cyc = 0;
    c.addr = 32'h80; c.we = 1'b1; c.wdata = 32'h1234_5678;
    d_q.push_back(c);
    c.we = 1'b0;
    d_q.push_back(c);
    wait_idle();
    check_eq("write_we_cycles", 64'(n_we_cyc), 64'(LAT));
    check_eq("read_back_80", last_d_rd, 32'h1234_5678);

    // Random traffic
    rand_mode = 1'b1;
    repeat (1500) step();
    rand_mode = 1'b0;
    wait_idle();

    // Reset during the second ACCESS cycle of a write
    c.addr = 32'h20; c.we = 1'b1; c.wdata = $urandom;
    d_q.push_back(c);
    n = 0;
    m_g_d = 1'b0;
    while (!m_g_d && n < 20) begin step(); n++; end
    check_eq("rst_wr_gnt_seen", m_g_d, 64'd1);
    @(posedge clk);
    #1;
    check_eq("pre_rst_mem_we", bus.mem_we, 64'd1);
    rst = 1'b0;
    #1;
    check_eq("async_mem_we", bus.mem_we, 64'd0);
    check_eq("async_mem_re", bus.mem_re, 64'd0);
    check_eq("async_mem_addr", bus.mem_addr, 64'd0);
    check_eq("async_d_rdata", bus.d_rdata, 64'd0);
    check_eq("async_if_rdata", bus.if_rdata, 64'd0);
    d_out = 1'b0;
    bus.d_req = 1'b1; bus.d_addr = d_cur.addr; bus.d_we = d_cur.we; bus.d_wdata = d_cur.wdata;
    step();
    rst = 1'b1;
    n = 0;
    m_g_d = 1'b0;
    while (!m_g_d && n < 10) begin step(); n++; end
    check_eq("post_rst_regrant", m_g_d, 64'd1);
    wait_idle();

    n = 0;
    while (n < 2000 && !(g_aux[0].done && g_aux[1].done)) begin @(negedge clk); n++; end
    check_eq("aux_done", 64'(g_aux[0].done && g_aux[1].done), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
